// File: rtl/ray_generator.sv
// Camera ray source: walks an IMG_W x IMG_H frame in raster order and streams one
// 6-word ray (origin xyz, direction xyz) per pixel into a downstream FIFO.
module ray_generator #(
  parameter int D_BITS = 32,
  parameter int Q_BITS = 10,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int X_BITS = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  parameter int Y_BITS = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic signed [D_BITS-1:0] cam_origin [2:0],
  input  logic signed [D_BITS-1:0] cam_corner [2:0],
  input  logic signed [D_BITS-1:0] cam_du     [2:0],
  input  logic signed [D_BITS-1:0] cam_dv     [2:0],
  input  logic                     out_full,
  output logic                     out_wr_en,
  output logic signed [D_BITS-1:0] ray_out    [5:0],
  output logic [X_BITS-1:0]        pixel_x,
  output logic [Y_BITS-1:0]        pixel_y
);

  if (Q_BITS < 0 || Q_BITS >= D_BITS) begin : g_bad_q_bits
    $error("ray_generator: Q_BITS must lie in [0, D_BITS)");
  end

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(IMG_W - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [D_BITS-1:0] origin_q  [2:0], origin_d  [2:0];
  logic signed [D_BITS-1:0] du_q      [2:0], du_d      [2:0];
  logic signed [D_BITS-1:0] dv_q      [2:0], dv_d      [2:0];
  logic signed [D_BITS-1:0] row_acc_q [2:0], row_acc_d [2:0];
  logic signed [D_BITS-1:0] dir_acc_q [2:0], dir_acc_d [2:0];
  logic signed [D_BITS-1:0] row_next  [2:0];
  logic [X_BITS-1:0]        x_q, x_d;
  logic [Y_BITS-1:0]        y_q, y_d;

  always_comb begin
    state_d   = state_q;
    origin_d  = origin_q;
    du_d      = du_q;
    dv_d      = dv_q;
    row_acc_d = row_acc_q;
    dir_acc_d = dir_acc_q;
    x_d       = x_q;
    y_d       = y_q;
    busy      = 1'b0;
    done      = 1'b0;
    out_wr_en = 1'b0;

    // One adder per axis serves both the row accumulator and the first direction of the new row.
    for (int unsigned k = 0; k < 3; k++) begin
      row_next[k] = row_acc_q[k] + dv_q[k];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          origin_d  = cam_origin;
          du_d      = cam_du;
          dv_d      = cam_dv;
          row_acc_d = cam_corner;
          dir_acc_d = cam_corner;
          x_d       = '0;
          y_d       = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        busy      = 1'b1;
        out_wr_en = !out_full;
        if (!out_full) begin
          if (x_q != X_LAST) begin
            x_d = x_q + X_BITS'(1);
            for (int unsigned k = 0; k < 3; k++) begin
              dir_acc_d[k] = dir_acc_q[k] + du_q[k];
            end
          end else if (y_q != Y_LAST) begin
            x_d       = '0;
            y_d       = y_q + Y_BITS'(1);
            row_acc_d = row_next;
            dir_acc_d = row_next;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned k = 0; k < 3; k++) begin
      ray_out[k]     = origin_q[k];
      ray_out[k + 3] = dir_acc_q[k];
    end
    pixel_x = x_q;
    pixel_y = y_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      origin_q  <= '{default: '0};
      du_q      <= '{default: '0};
      dv_q      <= '{default: '0};
      row_acc_q <= '{default: '0};
      dir_acc_q <= '{default: '0};
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      origin_q  <= origin_d;
      du_q      <= du_d;
      dv_q      <= dv_d;
      row_acc_q <= row_acc_d;
      dir_acc_q <= dir_acc_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

endmodule

// File: tb/tb_ray_generator.sv
// Scoreboard bench for ray_generator: a 4x3 instance for directed scenarios and an
// 8x8 instance for random backpressure.
module tb_ray_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]        x;
    logic [7:0]        y;
    logic [5:0][31:0]  ray;
  } sb_item_t;

  // ---------------- instance A: 4x3 ----------------
  logic               a_rst, a_start, a_busy, a_done, a_full, a_wr_en;
  logic signed [31:0] a_origin [2:0], a_corner [2:0], a_du [2:0], a_dv [2:0];
  logic signed [31:0] a_ray [5:0];
  logic [1:0]         a_px, a_py;
  sb_item_t           sb_a [$];
  sb_item_t           e_a;

  ray_generator #(.D_BITS(32), .Q_BITS(10), .IMG_W(4), .IMG_H(3)) dut_a (
    .clock(clk), .reset(a_rst), .start(a_start), .busy(a_busy), .done(a_done),
    .cam_origin(a_origin), .cam_corner(a_corner), .cam_du(a_du), .cam_dv(a_dv),
    .out_full(a_full), .out_wr_en(a_wr_en), .ray_out(a_ray),
    .pixel_x(a_px), .pixel_y(a_py)
  );

  // ---------------- instance B: 8x8 ----------------
  logic               b_rst, b_start, b_busy, b_done, b_full, b_wr_en;
  logic signed [31:0] b_origin [2:0], b_corner [2:0], b_du [2:0], b_dv [2:0];
  logic signed [31:0] b_ray [5:0];
  logic [2:0]         b_px, b_py;
  sb_item_t           sb_b [$];
  sb_item_t           e_b;

  ray_generator #(.D_BITS(32), .Q_BITS(10), .IMG_W(8), .IMG_H(8)) dut_b (
    .clock(clk), .reset(b_rst), .start(b_start), .busy(b_busy), .done(b_done),
    .cam_origin(b_origin), .cam_corner(b_corner), .cam_du(b_du), .cam_dv(b_dv),
    .out_full(b_full), .out_wr_en(b_wr_en), .ray_out(b_ray),
    .pixel_x(b_px), .pixel_y(b_py)
  );

  // Reference ray for pixel (x,y): direct closed form, wrapping mod 2^32.
  function automatic sb_item_t mk(input int x, input int y,
                                  input logic signed [31:0] o  [2:0],
                                  input logic signed [31:0] c  [2:0],
                                  input logic signed [31:0] du [2:0],
                                  input logic signed [31:0] dv [2:0]);
    sb_item_t r;
    r.x = 8'(x);
    r.y = 8'(y);
    for (int k = 0; k < 3; k++) begin
      r.ray[k]     = o[k];
      r.ray[k + 3] = c[k] + 32'(x) * du[k] + 32'(y) * dv[k];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (a_wr_en === 1'b1) begin
      checks++;
      if (sb_a.size() == 0) begin
        failures++;
        $display("FAIL a_extra_write got px=%0d py=%0d required no write", a_px, a_py);
      end else begin
        e_a = sb_a.pop_front();
        if ({a_ray[5], a_ray[4], a_ray[3], a_ray[2], a_ray[1], a_ray[0]} !== e_a.ray ||
            {6'b0, a_px} !== e_a.x || {6'b0, a_py} !== e_a.y) begin
          failures++;
          $display("FAIL a_ray got px=%0d py=%0d dir=(%0d,%0d,%0d) org=(%0d,%0d,%0d) required px=%0d py=%0d ray=%h",
                   a_px, a_py, a_ray[3], a_ray[4], a_ray[5], a_ray[0], a_ray[1], a_ray[2],
                   e_a.x, e_a.y, e_a.ray);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_wr_en === 1'b1) begin
      checks++;
      if (sb_b.size() == 0) begin
        failures++;
        $display("FAIL b_extra_write got px=%0d py=%0d required no write", b_px, b_py);
      end else begin
        e_b = sb_b.pop_front();
        if ({b_ray[5], b_ray[4], b_ray[3], b_ray[2], b_ray[1], b_ray[0]} !== e_b.ray ||
            {5'b0, b_px} !== e_b.x || {5'b0, b_py} !== e_b.y) begin
          failures++;
          $display("FAIL b_ray got px=%0d py=%0d ray=%h,%h,%h,%h,%h,%h required px=%0d py=%0d ray=%h",
                   b_px, b_py, b_ray[5], b_ray[4], b_ray[3], b_ray[2], b_ray[1], b_ray[0],
                   e_b.x, e_b.y, e_b.ray);
        end
      end
    end
  end

  task automatic set_basic_a();
    a_origin[0] = 1024;  a_origin[1] = 2048;  a_origin[2] = 3072;
    a_corner[0] = -2048; a_corner[1] = 1536;  a_corner[2] = 1024;
    a_du[0]     = 1024;  a_du[1]     = 0;     a_du[2]     = 0;
    a_dv[0]     = 0;     a_dv[1]     = -1024; a_dv[2]     = 0;
  endtask

  task automatic push_frame_a();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        sb_a.push_back(mk(x, y, a_origin, a_corner, a_du, a_dv));
  endtask

  // Runs A from a start already driven just after a posedge, until one cycle past done.
  task automatic run_a(input int stall_after, input int stall_len, input int restart_at,
                       output int writes, output int dones, output int done_ok,
                       output int busy_bad, output int stall_bad, output int stalls,
                       output int first_wr);
    int  stalled;
    bit  prev_wr, fin, restarted;
    stalled = 0; prev_wr = 0; fin = 0; restarted = 0;
    writes = 0; dones = 0; done_ok = 0; busy_bad = 0; stall_bad = 0; stalls = 0; first_wr = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(posedge clk); #1;
      a_start = 1'b0;
      if (restart_at >= 0 && writes == restart_at && !restarted) begin
        a_start     = 1'b1;
        a_corner[0] = 32'sh0001_2345;
        a_du[1]     = 77;
        a_dv[2]     = -5;
        restarted   = 1;
      end
      if (stall_after >= 0 && writes == stall_after && stalled < stall_len) begin
        a_full = 1'b1;
        stalled++;
      end else begin
        a_full = 1'b0;
      end
      @(negedge clk);
      if (c == 0) first_wr = (a_wr_en === 1'b1) ? 1 : 0;
      if (a_full) begin
        stalls++;
        if (a_wr_en !== 1'b0 || sb_a.size() == 0 ||
            {a_ray[5], a_ray[4], a_ray[3], a_ray[2], a_ray[1], a_ray[0]} !== sb_a[0].ray ||
            {6'b0, a_px} !== sb_a[0].x)
          stall_bad++;
      end
      if (a_done === 1'b1) begin
        if (a_busy !== 1'b0 || a_wr_en !== 1'b0) busy_bad++;
      end else if (dones == 0 && a_busy !== 1'b1) begin
        busy_bad++;
      end
      if (a_wr_en === 1'b1) writes++;
      if (a_done === 1'b1) begin
        dones++;
        if (prev_wr && writes == 12) done_ok = 1;
      end else if (dones > 0) begin
        fin = 1;
      end
      prev_wr = (a_wr_en === 1'b1);
    end
    a_full  = 1'b0;
    a_start = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0 || a_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got busy=%b done=%b wr=%b required 0 0 0", a_busy, a_done, a_wr_en);
    end
    checks++;
    if (a_px !== 2'd0 || a_py !== 2'd0 || b_px !== 3'd0 || b_py !== 3'd0) begin
      failures++;
      $display("FAIL reset_pixel got a=(%0d,%0d) b=(%0d,%0d) required zeros", a_px, a_py, b_px, b_py);
    end
    checks++;
    if ({a_ray[5], a_ray[4], a_ray[3], a_ray[2], a_ray[1], a_ray[0]} !== 192'd0) begin
      failures++;
      $display("FAIL reset_ray got %h,%h,%h required zeros", a_ray[0], a_ray[3], a_ray[5]);
    end
    checks++;
    if (b_busy !== 1'b0 || b_wr_en !== 1'b0 || b_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_b got busy=%b wr=%b done=%b required 0 0 0", b_busy, b_wr_en, b_done);
    end
    @(posedge clk); #1;
    a_rst = 1'b0; b_rst = 1'b0;
  endtask

  task automatic check_frame_a(input string tag, input int writes, input int dones,
                               input int done_ok, input int busy_bad, input int first_wr);
    checks++;
    if (writes != 12) begin
      failures++;
      $display("FAIL %s_writes got %0d required 12", tag, writes);
    end
    checks++;
    if (dones != 1 || done_ok != 1) begin
      failures++;
      $display("FAIL %s_done got pulses=%0d after_last=%0d required 1 1", tag, dones, done_ok);
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL %s_busy got bad_cycles=%0d required 0", tag, busy_bad);
    end
    checks++;
    if (first_wr != 1) begin
      failures++;
      $display("FAIL %s_latency got first_wr=%0d required 1", tag, first_wr);
    end
    checks++;
    if (sb_a.size() != 0) begin
      failures++;
      $display("FAIL %s_left got %0d rays outstanding required 0", tag, sb_a.size());
      sb_a.delete();
    end
  endtask

  task automatic test_basic_frame();
    int w, d, ok, bb, sb, st, fw;
    set_basic_a();
    push_frame_a();
    @(posedge clk); #1;
    a_start = 1'b1;
    run_a(-1, 0, -1, w, d, ok, bb, sb, st, fw);
    check_frame_a("basic", w, d, ok, bb, fw);
  endtask

  task automatic test_backpressure();
    int w, d, ok, bb, sb, st, fw;
    set_basic_a();
    push_frame_a();
    @(posedge clk); #1;
    a_start = 1'b1;
    run_a(2, 5, -1, w, d, ok, bb, sb, st, fw);
    check_frame_a("stall", w, d, ok, bb, fw);
    checks++;
    if (st != 5 || sb != 0) begin
      failures++;
      $display("FAIL stall_hold got stall_cycles=%0d bad=%0d required 5 0", st, sb);
    end
  endtask

  task automatic test_start_ignored();
    int w, d, ok, bb, sb, st, fw;
    set_basic_a();
    push_frame_a();
    @(posedge clk); #1;
    a_start = 1'b1;
    run_a(-1, 0, 4, w, d, ok, bb, sb, st, fw);
    check_frame_a("restart", w, d, ok, bb, fw);
    set_basic_a();
  endtask

  task automatic test_back_to_back();
    int w, d, ok, bb, sb, st, fw;
    set_basic_a();
    push_frame_a();
    push_frame_a();
    @(posedge clk); #1;
    a_start = 1'b1;
    run_a(-1, 0, -1, w, d, ok, bb, sb, st, fw);
    // Now in the first IDLE cycle after DONE: assert start for this cycle's edge.
    a_start = 1'b1;
    run_a(-1, 0, -1, w, d, ok, bb, sb, st, fw);
    check_frame_a("b2b", w, d, ok, bb, fw);
  endtask

  task automatic test_reset_midframe();
    int w, d, ok, bb, sb, st, fw, extra;
    set_basic_a();
    push_frame_a();
    @(posedge clk); #1;
    a_start = 1'b1;
    w = 0;
    for (int c = 0; c < 50 && w < 5; c++) begin
      @(posedge clk); #1;
      a_start = 1'b0;
      @(negedge clk);
      if (a_wr_en === 1'b1) w++;
    end
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (w != 5 || a_wr_en !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_after got writes=%0d wr=%b busy=%b done=%b required 5 0 0 0",
               w, a_wr_en, a_busy, a_done);
    end
    sb_a.delete();
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_wr_en !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL midreset_idle got active_cycles=%0d required 0", extra);
    end
    push_frame_a();
    @(posedge clk); #1;
    a_start = 1'b1;
    run_a(-1, 0, -1, w, d, ok, bb, sb, st, fw);
    check_frame_a("postreset", w, d, ok, bb, fw);
  endtask

  task automatic test_wrap();
    int w, d, ok, bb, sb, st, fw;
    set_basic_a();
    a_corner[0] = 32'sh7FFF_FC00;
    push_frame_a();
    @(posedge clk); #1;
    a_start = 1'b1;
    // Ray 1 must carry x = 32'h8000_0000: watch it directly as well as through the scoreboard.
    @(posedge clk); #1;
    a_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_wr_en !== 1'b1 || a_px !== 2'd1 || a_ray[3] !== 32'sh8000_0000) begin
      failures++;
      $display("FAIL wrap_ray1 got wr=%b px=%0d dirx=%h required 1 1 80000000", a_wr_en, a_px, a_ray[3]);
    end
    for (int c = 0; c < 40 && a_done !== 1'b1; c++) @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || sb_a.size() != 0) begin
      failures++;
      $display("FAIL wrap_frame got done=%b left=%0d required 1 0", a_done, sb_a.size());
      sb_a.delete();
    end
    @(negedge clk);
    set_basic_a();
  endtask

  task automatic test_random_backpressure();
    int w, d, fin;
    for (int k = 0; k < 3; k++) begin
      b_origin[k] = $urandom;
      b_corner[k] = $urandom;
      b_du[k]     = $urandom;
      b_dv[k]     = $urandom;
    end
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        sb_b.push_back(mk(x, y, b_origin, b_corner, b_du, b_dv));
    @(posedge clk); #1;
    b_start = 1'b1;
    w = 0; d = 0; fin = 0;
    for (int c = 0; c < 1000 && !fin; c++) begin
      @(posedge clk); #1;
      b_start = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      if (d > 0) b_start = 1'b0;
      b_full = ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0;
      for (int k = 0; k < 3; k++) b_corner[k] = $urandom;
      @(negedge clk);
      if (b_wr_en === 1'b1) w++;
      if (b_done === 1'b1) d++;
      else if (d > 0) fin = 1;
    end
    b_full = 1'b0; b_start = 1'b0;
    checks++;
    if (w != 64 || d != 1) begin
      failures++;
      $display("FAIL rand_frame got writes=%0d dones=%0d required 64 1", w, d);
    end
    checks++;
    if (sb_b.size() != 0) begin
      failures++;
      $display("FAIL rand_left got %0d rays outstanding required 0", sb_b.size());
    end
  endtask

  initial begin
    a_rst = 1'b1; a_start = 1'b0; a_full = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_origin[k] = 0; a_corner[k] = 0; a_du[k] = 0; a_dv[k] = 0;
      b_origin[k] = 0; b_corner[k] = 0; b_du[k] = 0; b_dv[k] = 0;
    end
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
    test_reset_midframe();
    test_wrap();
    test_random_backpressure();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
